i2s_rx_deser: RTL and testbench

Serial-to-parallel I2S receiver that turns the codec ADC stream (bit clock, word select, serial data) into signed parallel samples plus a one-cycle `valid` strobe in the system clock domain. It sits at the front of the audio path. Its `data`/`valid` outputs drive the input sample-hold register directly, which latches on `valid`. All I2S pins are sampled by the fast system clock; the block generates no clocks.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/sync_edge_det.sv | 49 ++++
 rtl/i2s_rx_deser.sv | 165 ++++++++++++++++
 tb/tb_i2s_rx_deser.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S receive path.
// Optional input synchronizers are selected with I2S_RX_SYNC_EN.
package i2s_pkg;

    typedef enum logic [1:0] {
        ALIGN,
        SHIFT,
        HOLD
    } i2s_rx_state_t;

    localparam logic I2S_CH_LEFT  = 1'b0;
    localparam logic I2S_CH_RIGHT = 1'b1;

    function automatic int bitcnt_w(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Optional 2-flop synchronizer plus rising-edge detector.
// Synchronizer present only when I2S_RX_SYNC_EN is defined.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

`ifdef I2S_RX_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
`else
    assign level = din;
`endif

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign rise = level & ~hist_q;

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S serial-to-parallel receiver with valid/frame_err strobes.
// Define I2S_RX_SYNC_EN to insert 2-flop pin synchronizers.
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int size = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i2s_bclk,
    input  logic            i2s_lrclk,
    input  logic            i2s_sdata,
    output logic [size-1:0] data,
    output logic            valid,
    output logic            channel,
    output logic            frame_err
);

    localparam int CW = bitcnt_w(size);

    logic lr_s;
    logic sd_s;

`ifdef I2S_RX_SYNC_EN
    logic [1:0] lr_sync_q, lr_sync_d;
    logic [1:0] sd_sync_q, sd_sync_d;

    always_comb begin
        lr_sync_d = {lr_sync_q[0], i2s_lrclk};
        sd_sync_d = {sd_sync_q[0], i2s_sdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lr_sync_q <= '0;
            sd_sync_q <= '0;
        end else begin
            lr_sync_q <= lr_sync_d;
            sd_sync_q <= sd_sync_d;
        end
    end

    assign lr_s = lr_sync_q[1];
    assign sd_s = sd_sync_q[1];
`else
    assign lr_s = i2s_lrclk;
    assign sd_s = i2s_sdata;
`endif

    logic bclk_lvl;
    logic bclk_rise;

    sync_edge_det u_bclk (
        .clk   (clk),
        .rst   (rst),
        .din   (i2s_bclk),
        .level (bclk_lvl),
        .rise  (bclk_rise)
    );

    i2s_rx_state_t   state_q, state_d;
    logic            lr_prev_q, lr_prev_d;
    logic            cur_ch_q, cur_ch_d;
    logic [size-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    logic [size-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            channel_q, channel_d;
    logic            ferr_q, ferr_d;

    logic            step;
    logic            boundary;
    logic [size-1:0] shift_val;
    logic [CW-1:0]   cnt_inc;

    assign step      = bclk_rise & bclk_lvl;
    assign boundary  = step & (lr_s != lr_prev_q);
    assign shift_val = {shreg_q[size-2:0], sd_s};
    assign cnt_inc   = bitcnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        cur_ch_d  = cur_ch_q;
        shreg_d   = shreg_q;
        bitcnt_d  = bitcnt_q;
        data_d    = data_q;
        channel_d = channel_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        if (step) begin
            lr_prev_d = lr_s;
            unique case (state_q)
                ALIGN: begin
                    if (boundary) begin
                        cur_ch_d = lr_s;
                        bitcnt_d = '0;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_d  = shift_val;
                    bitcnt_d = cnt_inc;
                    if (cnt_inc == CW'(size)) begin
                        data_d    = shift_val;
                        channel_d = cur_ch_q;
                        valid_d   = 1'b1;
                        state_d   = HOLD;
                    end else if (boundary) begin
                        ferr_d = 1'b1;
                    end
                    // boundary overrides the HOLD transition of an exact-size slot
                    if (boundary) begin
                        shreg_d  = '0;
                        bitcnt_d = '0;
                        cur_ch_d = lr_s;
                        state_d  = SHIFT;
                    end
                end
                HOLD: begin
                    if (boundary) begin
                        shreg_d  = '0;
                        bitcnt_d = '0;
                        cur_ch_d = lr_s;
                        state_d  = SHIFT;
                    end
                end
                default: begin
                    state_d = ALIGN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ALIGN;
            lr_prev_q <= 1'b0;
            cur_ch_q  <= I2S_CH_LEFT;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            channel_q <= I2S_CH_LEFT;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            cur_ch_q  <= cur_ch_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            channel_q <= channel_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign channel   = channel_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: random I2S streams vs a slot-level model.
// Latency expectation follows I2S_RX_SYNC_EN.
module tb_i2s_rx_deser;

    localparam int SIZE = 16;
`ifdef I2S_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            bclk = 1'b0;
    logic            lrclk = 1'b0;
    logic            sdata = 1'b0;
    logic [SIZE-1:0] data;
    logic            valid;
    logic            channel;
    logic            frame_err;

    i2s_rx_deser #(.size(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .i2s_bclk  (bclk),
        .i2s_lrclk (lrclk),
        .i2s_sdata (sdata),
        .data      (data),
        .valid     (valid),
        .channel   (channel),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int both_seen = 0;
    int chk_n = 0;

    // stream history since last reset, one entry per bclk rise
    logic        hist_lr[$];
    logic        hist_sd[$];
    int          rise_cyc[$];
    logic [33:0] obs_ev[$];
    int          obs_cyc[$];
    logic [33:0] exp_ev[$];
    int          exp_at[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && frame_err) both_seen++;
        if (valid) begin
            obs_ev.push_back({1'b0, channel, 32'(data)});
            obs_cyc.push_back(cyc);
        end else if (frame_err) begin
            obs_ev.push_back({1'b1, 1'b0, 32'h0});
            obs_cyc.push_back(cyc);
        end
    end

    // slot-level reference: split the history at lrclk changes
    task automatic model();
        int b[$];
        logic prev;
        exp_ev.delete();
        exp_at.delete();
        for (int k = 0; k < hist_lr.size(); k++) begin
            prev = (k == 0) ? 1'b0 : hist_lr[k-1];
            if (hist_lr[k] != prev) b.push_back(k);
        end
        for (int i = 0; i < b.size(); i++) begin
            int st, en, len;
            bit closed;
            logic [31:0] w;
            st = b[i] + 1;
            closed = (i + 1 < b.size());
            en = closed ? b[i+1] : hist_lr.size() - 1;
            len = en - st + 1;
            if (len >= SIZE) begin
                w = 0;
                for (int j = 0; j < SIZE; j++) w = {w[30:0], hist_sd[st+j]};
                exp_ev.push_back({1'b0, hist_lr[b[i]], w});
                exp_at.push_back(st + SIZE - 1);
            end else if (closed) begin
                exp_ev.push_back({1'b1, 1'b0, 32'h0});
                exp_at.push_back(en);
            end
        end
    endtask

    task automatic send_bit(input logic lr, input logic sd);
        @(negedge clk);
        bclk = 1'b0;
        lrclk = lr;
        sdata = sd;
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        rise_cyc.push_back(cyc);
        hist_lr.push_back(lr);
        hist_sd.push_back(sd);
        repeat (4) @(negedge clk);
    endtask

    // lrclk switches to nxt on the slot's last bit (one-bit I2S delay)
    task automatic send_slot(input logic nxt, input logic ch,
                             input int width, input logic [31:0] w);
        for (int i = 0; i < width; i++) begin
            send_bit((i == width - 1) ? nxt : ch, w[width-1-i]);
        end
        @(negedge clk);
        bclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bclk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hist_lr.delete();
        hist_sd.delete();
        rise_cyc.delete();
        obs_ev.delete();
        obs_cyc.delete();
        chk_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();
        checks++;
        if (data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", data);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", valid);
        end
        checks++;
        if (channel !== 1'b0) begin
            failures++;
            $display("FAIL reset_channel got=%b exp=0", channel);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ferr got=%b exp=0", frame_err);
        end
    endtask

    task automatic test_align();
        send_slot(1'b1, 1'b0, 12, $urandom);
        checks++;
        if (obs_ev.size() != 0) begin
            failures++;
            $display("FAIL align_early got=%0d exp=0", obs_ev.size());
        end
        send_slot(1'b0, 1'b1, 16, $urandom);
        model();
        for (int i = chk_n; i < exp_ev.size(); i++) begin
            checks++;
            if (i >= obs_ev.size()) begin
                failures++;
                $display("FAIL align ev%0d missing exp=%h", i, exp_ev[i]);
            end else if (obs_ev[i] !== exp_ev[i] ||
                         obs_cyc[i] - rise_cyc[exp_at[i]] != LAT) begin
                failures++;
                $display("FAIL align ev%0d got=%h lat=%0d exp=%h lat=%0d", i,
                         obs_ev[i], obs_cyc[i] - rise_cyc[exp_at[i]],
                         exp_ev[i], LAT);
            end
        end
        checks++;
        if (obs_ev.size() != exp_ev.size() || exp_ev.size() != 1) begin
            failures++;
            $display("FAIL align_count got=%0d exp=%0d model=%0d",
                     obs_ev.size(), 1, exp_ev.size());
        end
        chk_n = exp_ev.size();
    endtask

    task automatic test_basic();
        send_slot(1'b1, 1'b0, 16, 32'h1234);
        send_slot(1'b0, 1'b1, 16, 32'hABCD);
        model();
        for (int i = chk_n; i < exp_ev.size(); i++) begin
            checks++;
            if (i >= obs_ev.size()) begin
                failures++;
                $display("FAIL basic ev%0d missing exp=%h", i, exp_ev[i]);
            end else if (obs_ev[i] !== exp_ev[i] ||
                         obs_cyc[i] - rise_cyc[exp_at[i]] != LAT) begin
                failures++;
                $display("FAIL basic ev%0d got=%h lat=%0d exp=%h lat=%0d", i,
                         obs_ev[i], obs_cyc[i] - rise_cyc[exp_at[i]],
                         exp_ev[i], LAT);
            end
        end
        checks++;
        if (obs_ev.size() < chk_n + 2 ||
            obs_ev[chk_n] !== {2'b00, 32'h1234} ||
            obs_ev[chk_n+1] !== {2'b01, 32'hABCD}) begin
            failures++;
            $display("FAIL basic_words got_n=%0d exp 1234/L then ABCD/R",
                     obs_ev.size() - chk_n);
        end
        chk_n = exp_ev.size();
    endtask

    task automatic test_wide();
        send_slot(1'b1, 1'b0, 32, {16'h8001, 16'hFFFF});
        send_slot(1'b0, 1'b1, 32, {16'($urandom), 16'hFFFF});
        model();
        for (int i = chk_n; i < exp_ev.size(); i++) begin
            checks++;
            if (i >= obs_ev.size()) begin
                failures++;
                $display("FAIL wide ev%0d missing exp=%h", i, exp_ev[i]);
            end else if (obs_ev[i] !== exp_ev[i] ||
                         obs_cyc[i] - rise_cyc[exp_at[i]] != LAT) begin
                failures++;
                $display("FAIL wide ev%0d got=%h lat=%0d exp=%h lat=%0d", i,
                         obs_ev[i], obs_cyc[i] - rise_cyc[exp_at[i]],
                         exp_ev[i], LAT);
            end
        end
        checks++;
        if (obs_ev.size() != exp_ev.size() || exp_ev.size() != chk_n + 2) begin
            failures++;
            $display("FAIL wide_count got=%0d exp=%0d",
                     obs_ev.size() - chk_n, 2);
        end
        chk_n = exp_ev.size();
    endtask

    task automatic test_frame_err();
        send_slot(1'b1, 1'b0, 10, $urandom);
        send_slot(1'b0, 1'b1, 16, $urandom);
        model();
        for (int i = chk_n; i < exp_ev.size(); i++) begin
            checks++;
            if (i >= obs_ev.size()) begin
                failures++;
                $display("FAIL ferr ev%0d missing exp=%h", i, exp_ev[i]);
            end else if (obs_ev[i] !== exp_ev[i] ||
                         obs_cyc[i] - rise_cyc[exp_at[i]] != LAT) begin
                failures++;
                $display("FAIL ferr ev%0d got=%h lat=%0d exp=%h lat=%0d", i,
                         obs_ev[i], obs_cyc[i] - rise_cyc[exp_at[i]],
                         exp_ev[i], LAT);
            end
        end
        checks++;
        if (obs_ev.size() != exp_ev.size() || obs_ev.size() < chk_n + 1 ||
            obs_ev[chk_n][33] !== 1'b1) begin
            failures++;
            $display("FAIL ferr_first got_n=%0d exp frame_err first",
                     obs_ev.size() - chk_n);
        end
        chk_n = exp_ev.size();
    endtask

    task automatic test_random();
        for (int s = 0; s < 10; s++) begin
            logic ch;
            ch = s[0];
            send_slot(~ch, ch, $urandom_range(8, 32), $urandom);
        end
        model();
        for (int i = chk_n; i < exp_ev.size(); i++) begin
            checks++;
            if (i >= obs_ev.size()) begin
                failures++;
                $display("FAIL rand ev%0d missing exp=%h", i, exp_ev[i]);
            end else if (obs_ev[i] !== exp_ev[i] ||
                         obs_cyc[i] - rise_cyc[exp_at[i]] != LAT) begin
                failures++;
                $display("FAIL rand ev%0d got=%h lat=%0d exp=%h lat=%0d", i,
                         obs_ev[i], obs_cyc[i] - rise_cyc[exp_at[i]],
                         exp_ev[i], LAT);
            end
        end
        checks++;
        if (obs_ev.size() != exp_ev.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=%0d",
                     obs_ev.size(), exp_ev.size());
        end
        chk_n = exp_ev.size();
    endtask

    task automatic test_reset_mid();
        send_slot(1'b0, 1'b0, 8, $urandom);
        do_reset();
        checks++;
        if ({data, valid, channel, frame_err} !== '0) begin
            failures++;
            $display("FAIL rstmid_outs got=%h/%b/%b/%b exp=0",
                     data, valid, channel, frame_err);
        end
        send_slot(1'b1, 1'b0, 8, $urandom);
        send_slot(1'b0, 1'b1, 16, $urandom);
        model();
        for (int i = chk_n; i < exp_ev.size(); i++) begin
            checks++;
            if (i >= obs_ev.size()) begin
                failures++;
                $display("FAIL rstmid ev%0d missing exp=%h", i, exp_ev[i]);
            end else if (obs_ev[i] !== exp_ev[i] ||
                         obs_cyc[i] - rise_cyc[exp_at[i]] != LAT) begin
                failures++;
                $display("FAIL rstmid ev%0d got=%h lat=%0d exp=%h lat=%0d", i,
                         obs_ev[i], obs_cyc[i] - rise_cyc[exp_at[i]],
                         exp_ev[i], LAT);
            end
        end
        checks++;
        if (obs_ev.size() != exp_ev.size() || exp_ev.size() != 1) begin
            failures++;
            $display("FAIL rstmid_count got=%0d exp=1", obs_ev.size());
        end
        chk_n = exp_ev.size();
        checks++;
        if (both_seen != 0) begin
            failures++;
            $display("FAIL both_strobes got=%0d exp=0", both_seen);
        end
    endtask

    initial begin
        test_reset();
        test_align();
        test_basic();
        test_wide();
        test_frame_err();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
